// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
// Scans an 8-digit common-anode 7-segment display one digit at a time.
// Every digit slot is a dark BLANK phase followed by a lit SHOW phase.
// New data waits in pending registers and moves into the shadow (displayed)
// registers only when the scan wraps from digit 7 back to digit 0, so a
// frame never mixes old and new digits.
module fnd_scan_driver #(
    parameter logic [19:0] ON_CYC        = 20'd50000,
    parameter logic [15:0] BLANK_CYC     = 16'd500,
    parameter logic [19:0] ON_CYC_SIM    = 20'd4,
    parameter logic [15:0] BLANK_CYC_SIM = 16'd2,
    parameter logic        USE_SIM       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] digit_data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_mask,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  com_n,
    output logic        frame_tick
);

    localparam logic [19:0] ON_EFF     = USE_SIM ? ON_CYC_SIM : ON_CYC;
    localparam logic [15:0] BLANK_EFF  = USE_SIM ? BLANK_CYC_SIM : BLANK_CYC;
    localparam logic [19:0] ON_LAST    = ON_EFF - 20'd1;
    localparam logic [19:0] BLANK_LAST = {4'd0, BLANK_EFF} - 20'd1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] cnt_q, cnt_d;

    // Shadow registers: what the current frame displays
    logic [31:0] data_q, data_d;
    logic [7:0]  dp_q, dp_d;
    logic [7:0]  mask_q, mask_d;

    // Pending registers: captured on load, committed at the frame boundary
    logic [31:0] pend_data_q, pend_data_d;
    logic [7:0]  pend_dp_q, pend_dp_d;
    logic [7:0]  pend_mask_q, pend_mask_d;
    logic        pend_vld_q, pend_vld_d;

    // Registered outputs
    logic [7:0]  com_n_q, com_n_d;
    logic [6:0]  seg_n_q, seg_n_d;
    logic        dp_n_q, dp_n_d;
    logic        frame_tick_q, frame_tick_d;

    logic [7:0]  lit_com_n;
    logic [3:0]  cur_nib;

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h7F;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Digit-select pattern for the current slot; a masked digit keeps all commons off
    for (genvar gi = 0; gi < 8; gi++) begin : g_com
        assign lit_com_n[gi] = ~((idx_q == 3'(gi)) && !mask_q[gi]);
    end

    assign cur_nib = data_q[{idx_q, 2'b00} +: 4];

    // Next-state, load/commit and output computation
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        dp_d         = dp_q;
        mask_d       = mask_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_mask_d  = pend_mask_q;
        pend_vld_d   = pend_vld_q;
        com_n_d      = com_n_q;
        seg_n_d      = seg_n_q;
        dp_n_d       = dp_n_q;
        frame_tick_d = 1'b0;

        if (load) begin
            pend_data_d = digit_data;
            pend_dp_d   = dp_in;
            pend_mask_d = blank_mask;
            pend_vld_d  = 1'b1;
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = 20'd0;
                    com_n_d = lit_com_n;
                    seg_n_d = hex_to_seg(cur_nib);
                    dp_n_d  = ~dp_q[idx_q];
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_SHOW: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = 20'd0;
                    com_n_d = 8'hFF;
                    seg_n_d = 7'h7F;
                    dp_n_d  = 1'b1;
                    if (idx_q == 3'd7) begin
                        idx_d        = 3'd0;
                        frame_tick_d = 1'b1;
                        // Frame boundary: pending data becomes the displayed data.
                        // A load on this same edge stays pending for the next frame.
                        if (pend_vld_q) begin
                            data_d = pend_data_q;
                            dp_d   = pend_dp_q;
                            mask_d = pend_mask_q;
                            if (!load) begin
                                pend_vld_d = 1'b0;
                            end
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = 20'd0;
            end
        endcase
    end

    // State, data and output registers with asynchronous reset to a dark display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            idx_q        <= 3'd0;
            cnt_q        <= 20'd0;
            data_q       <= 32'd0;
            dp_q         <= 8'd0;
            mask_q       <= 8'hFF;
            pend_data_q  <= 32'd0;
            pend_dp_q    <= 8'd0;
            pend_mask_q  <= 8'd0;
            pend_vld_q   <= 1'b0;
            com_n_q      <= 8'hFF;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            dp_q         <= dp_d;
            mask_q       <= mask_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_mask_q  <= pend_mask_d;
            pend_vld_q   <= pend_vld_d;
            com_n_q      <= com_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign com_n      = com_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver
// Table-driven bench for the FND scan driver with simulation timing
// (blank 2, on 4, slot 6, frame 48 cycles). Cycle 0 is the first cycle
// after reset release; cycle c is sampled on the falling edge before edge c+1.
module tb_fnd_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] digit_data;
    logic [7:0]  dp_in;
    logic [7:0]  blank_mask;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  com_n;
    logic        frame_tick;

    fnd_scan_driver #(
        .USE_SIM(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .com_n      (com_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         owner;
        logic [7:0] com;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  mask;
    } stim_t;

    exp_t  exp_tab[$];
    stim_t stim_tab[$];
    exp_t  sb_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int onehot_viol = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic add_exp(input int c, input int o, input logic [7:0] cm,
                           input logic [6:0] sg, input logic d, input logic t);
        exp_t e;
        e.cyc = c; e.owner = o; e.com = cm; e.seg = sg; e.dp = d; e.tick = t;
        exp_tab.push_back(e);
    endtask

    task automatic add_stim(input int c, input logic [31:0] d, input logic [7:0] p,
                            input logic [7:0] m);
        stim_t s;
        s.cyc = c; s.data = d; s.dp = p; s.mask = m;
        stim_tab.push_back(s);
    endtask

    // Move the expectations that a stimulus entry (or the initial state, -1) implies into the scoreboard
    task automatic push_owner(input int o);
        foreach (exp_tab[i]) if (exp_tab[i].owner == o) sb_q.push_back(exp_tab[i]);
    endtask

    // Compare every scoreboard entry due in the current cycle
    task automatic sample_cycle();
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check($sformatf("c%0d_com_n", cyc), {24'd0, com_n}, {24'd0, sb_q[i].com});
                check($sformatf("c%0d_seg_n", cyc), {25'd0, seg_n}, {25'd0, sb_q[i].seg});
                check($sformatf("c%0d_dp_n", cyc), {31'd0, dp_n}, {31'd0, sb_q[i].dp});
                check($sformatf("c%0d_tick", cyc), {31'd0, frame_tick}, {31'd0, sb_q[i].tick});
                sb_q.delete(i);
            end
        end
        if ($countones(~com_n) > 1) onehot_viol++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dark_cnt;

        // Loads: 0 first data, 1/2 double load, 3/4 load on commit edge, 5 masked, 6 discarded by reset
        add_stim(10,  32'h76543210, 8'h01, 8'h00);
        add_stim(60,  32'h11111111, 8'h00, 8'h00);
        add_stim(70,  32'h88888888, 8'h00, 8'h00);
        add_stim(100, 32'hAAAAAAAA, 8'h00, 8'h00);
        add_stim(143, 32'hCCCCCCCC, 8'h00, 8'h00);
        add_stim(200, 32'hFEDCBA98, 8'h04, 8'h0A);
        add_stim(300, 32'h12345678, 8'h00, 8'h00);

        // Frame 0: dark display (mask all ones), no tick until cycle 48
        add_exp(0,   -1, 8'hFF, 7'h7F, 1'b1, 1'b0);
        add_exp(2,   -1, 8'hFF, 7'h40, 1'b1, 1'b0);
        add_exp(47,  -1, 8'hFF, 7'h40, 1'b1, 1'b0);
        add_exp(48,  -1, 8'hFF, 7'h7F, 1'b1, 1'b1);
        add_exp(49,  -1, 8'hFF, 7'h7F, 1'b1, 1'b0);
        add_exp(96,  -1, 8'hFF, 7'h7F, 1'b1, 1'b1);
        add_exp(144, -1, 8'hFF, 7'h7F, 1'b1, 1'b1);
        add_exp(192, -1, 8'hFF, 7'h7F, 1'b1, 1'b1);
        // Frame 1: 76543210, dp on digit 0; the mid-frame loads must not disturb it
        add_exp(50,  0, 8'hFE, 7'h40, 1'b0, 1'b0);
        add_exp(53,  0, 8'hFE, 7'h40, 1'b0, 1'b0);
        add_exp(54,  0, 8'hFF, 7'h7F, 1'b1, 1'b0);
        add_exp(56,  0, 8'hFD, 7'h79, 1'b1, 1'b0);
        add_exp(74,  0, 8'hEF, 7'h19, 1'b1, 1'b0);
        add_exp(92,  0, 8'h7F, 7'h78, 1'b1, 1'b0);
        // Frame 2: last of the two loads wins
        add_exp(98,  2, 8'hFE, 7'h00, 1'b1, 1'b0);
        add_exp(128, 2, 8'hDF, 7'h00, 1'b1, 1'b0);
        add_exp(143, 2, 8'h7F, 7'h00, 1'b1, 1'b0);
        // Frame 3 shows the older pending value, frame 4 the one loaded on the commit edge
        add_exp(146, 3, 8'hFE, 7'h08, 1'b1, 1'b0);
        add_exp(194, 4, 8'hFE, 7'h46, 1'b1, 1'b0);
        // Frame 5: digits 1 and 3 masked, digit 2 in its normal slot with dp
        add_exp(242, 5, 8'hFE, 7'h00, 1'b1, 1'b0);
        add_exp(248, 5, 8'hFF, 7'h10, 1'b1, 1'b0);
        add_exp(254, 5, 8'hFB, 7'h08, 1'b0, 1'b0);
        add_exp(257, 5, 8'hFB, 7'h08, 1'b0, 1'b0);
        add_exp(258, 5, 8'hFF, 7'h7F, 1'b1, 1'b0);
        add_exp(260, 5, 8'hFF, 7'h03, 1'b1, 1'b0);
        add_exp(266, 5, 8'hEF, 7'h46, 1'b1, 1'b0);

        rst_n = 1'b0;
        load = 1'b0;
        digit_data = 32'd0;
        dp_in = 8'd0;
        blank_mask = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_com_n", {24'd0, com_n}, 32'h0000_00FF);
        check("rst_seg_n", {25'd0, seg_n}, 32'h0000_007F);
        check("rst_dp_n", {31'd0, dp_n}, 32'd1);
        check("rst_tick", {31'd0, frame_tick}, 32'd0);
        rst_n = 1'b1;
        push_owner(-1);

        // Main run: cycles 0..320
        for (int c = 0; c <= 320; c++) begin
            cyc = c;
            load = 1'b0;
            foreach (stim_tab[s]) begin
                if (stim_tab[s].cyc == c) begin
                    load = 1'b1;
                    digit_data = stim_tab[s].data;
                    dp_in = stim_tab[s].dp;
                    blank_mask = stim_tab[s].mask;
                    push_owner(s);
                    $display("cycle %0d: load data=%h dp=%h mask=%h", c, stim_tab[s].data,
                             stim_tab[s].dp, stim_tab[s].mask);
                end
            end
            @(negedge clk);
            sample_cycle();
            @(posedge clk);
            #1;
        end
        load = 1'b0;

        // Cycle 321: digit 5 (D) lit, then asynchronous reset mid-slot
        cyc = 321;
        @(negedge clk);
        check("d5_lit_com_n", {24'd0, com_n}, 32'h0000_00DF);
        check("d5_lit_seg_n", {25'd0, seg_n}, 32'h0000_0021);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_com_n", {24'd0, com_n}, 32'h0000_00FF);
        check("async_rst_seg_n", {25'd0, seg_n}, 32'h0000_007F);
        check("async_rst_dp_n", {31'd0, dp_n}, 32'd1);
        check("async_rst_tick", {31'd0, frame_tick}, 32'd0);
        $display("cycle 321: reset asserted while digit 5 lit");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // After reset the pending load is gone: two dark frames, ticks still arrive
        dark_cnt = 0;
        for (int c = 0; c <= 100; c++) begin
            cyc = c;
            @(negedge clk);
            if (com_n != 8'hFF) dark_cnt++;
            if ($countones(~com_n) > 1) onehot_viol++;
            if (c == 47) check("post_rst_tick47", {31'd0, frame_tick}, 32'd0);
            if (c == 48) check("post_rst_tick48", {31'd0, frame_tick}, 32'd1);
            @(posedge clk);
            #1;
        end
        $display("post-reset scan: %0d lit cycles", dark_cnt);
        check("post_rst_dark", dark_cnt, 32'd0);
        check("com_onehot", onehot_viol, 32'd0);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
